// File: rtl/vram_dp.sv
// Dual-port video RAM: registered CPU read/write port, autonomous
// scan-out stream with a 2-entry skid buffer, and a full-array clear engine.
module vram_dp #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 10,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out,
    input  logic              clear_req,
    output logic              busy,
    input  logic              scan_start,
    input  logic [ADDR_W-1:0] scan_base,
    input  logic [ADDR_W:0]   scan_len,
    output logic              scan_valid,
    input  logic              scan_ready,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_last,
    output logic              scan_done
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   L_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_TOP = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued;

    logic              rd_pend;
    logic              rd_last;
    logic [DATA_W-1:0] rd_q;

    logic [DATA_W-1:0] buf_d0;
    logic [DATA_W-1:0] buf_d1;
    logic              buf_l0;
    logic              buf_l1;
    logic [1:0]        count;

    logic              clearing;
    logic              cpu_we;
    logic              pop;
    logic              issue;
    logic              issue_last;
    logic [2:0]        occ;
    logic [ADDR_W-1:0] rd_addr;

    assign clearing   = (state == S_CLEAR);
    assign cpu_we     = we && !clearing;
    assign busy       = (state != S_IDLE);
    assign scan_done  = (state == S_DONE);
    assign scan_valid = (state == S_SCAN) && (count != 2'd0);
    assign scan_data  = buf_d0;
    assign scan_last  = scan_valid && buf_l0;
    assign pop        = scan_valid && scan_ready;

    // Words in the buffer plus the read in flight; a pop this cycle frees a slot.
    assign occ        = {1'b0, count} + {2'b00, rd_pend};
    assign issue      = (state == S_SCAN) && (issued != len_q)
                      && (occ < (3'd2 + {2'b00, pop}));
    assign issue_last = (issued == (len_q - L_ONE));
    assign rd_addr    = base_q + issued[ADDR_W-1:0];

    // Array write port (clear engine has priority) and scan read port.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_addr] <= CLEAR_VALUE;
        end else if (we) begin
            mem[addr] <= data;
        end
        rd_q <= mem[rd_addr];
    end

    // CPU registered read, write-first on a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (cpu_we) begin
            out <= data;
        end else begin
            out <= mem[addr];
        end
    end

    // Control FSM, clear address counter and scan read issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            clr_addr <= '0;
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            rd_pend  <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                issued  <= issued + L_ONE;
                rd_last <= issue_last;
            end
            unique case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                    end else if (scan_start) begin
                        base_q <= scan_base;
                        len_q  <= scan_len;
                        issued <= '0;
                        state  <= (scan_len == '0) ? S_DONE : S_SCAN;
                    end
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + A_ONE;
                    if (clr_addr == A_TOP) begin
                        state <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (pop && buf_l0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-entry skid buffer; entry 0 is the head presented on the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_d0 <= '0;
            buf_d1 <= '0;
            buf_l0 <= 1'b0;
            buf_l1 <= 1'b0;
            count  <= 2'd0;
        end else begin
            unique case ({rd_pend, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        buf_d0 <= rd_q;
                        buf_l0 <= rd_last;
                    end else begin
                        buf_d1 <= rd_q;
                        buf_l1 <= rd_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf_d0 <= buf_d1;
                    buf_l0 <= buf_l1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf_d0 <= rd_q;
                        buf_l0 <= rd_last;
                    end else begin
                        buf_d0 <= buf_d1;
                        buf_l0 <= buf_l1;
                        buf_d1 <= rd_q;
                        buf_l1 <= rd_last;
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_dp.sv
// Testbench for vram_dp: table-driven CPU vectors, randomized CPU and scan
// traffic checked against a plain array model of the video RAM.
module tb_vram_dp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [9:0]  addr;
    logic [7:0]  data;
    logic [7:0]  out;
    logic        clear_req;
    logic        busy;
    logic        scan_start;
    logic [9:0]  scan_base;
    logic [10:0] scan_len;
    logic        scan_valid;
    logic        scan_ready;
    logic [7:0]  scan_data;
    logic        scan_last;
    logic        scan_done;

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_mem [1024];

    typedef struct {
        logic       we;
        logic [9:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [7];

    vram_dp #(.DATA_W(8), .ADDR_W(10), .CLEAR_VALUE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data),
        .out(out), .clear_req(clear_req), .busy(busy),
        .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
        .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_data(scan_data), .scan_last(scan_last), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input int a, input int d);
        we = 1'b1;
        addr = a[9:0];
        data = d[7:0];
        tick();
        we = 1'b0;
        ref_mem[a] = d[7:0];
    endtask

    task automatic cpu_read(input int a, input string name);
        we = 1'b0;
        addr = a[9:0];
        tick();
        chk(name, int'(out), int'(ref_mem[a]));
    endtask

    task automatic do_scan(input int base, input int len,
                           input bit rand_rdy, input string tag);
        logic [7:0] q [$];
        int beat;
        int cyc;
        int limit;
        bit rdy;
        for (int i = 0; i < len; i++) begin
            q.push_back(ref_mem[(base + i) % 1024]);
        end
        scan_base = base[9:0];
        scan_len = len[10:0];
        scan_ready = 1'b0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        if (len == 0) begin
            chk({tag, " zero done"}, int'(scan_done), 1);
            chk({tag, " zero valid"}, int'(scan_valid), 0);
            tick();
            chk({tag, " zero done end"}, int'(scan_done), 0);
            chk({tag, " zero busy end"}, int'(busy), 0);
            return;
        end
        chk({tag, " valid N+0"}, int'(scan_valid), 0);
        tick();
        chk({tag, " valid N+1"}, int'(scan_valid), 0);
        tick();
        chk({tag, " valid N+2"}, int'(scan_valid), 1);
        beat = 0;
        cyc = 0;
        limit = len * 8 + 20;
        while (beat < len && cyc < limit) begin
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            scan_ready = rdy;
            if (scan_valid) begin
                chk({tag, " data"}, int'(scan_data), int'(q[beat]));
                chk({tag, " last"}, int'(scan_last), int'(beat == len - 1));
                if (rdy) beat++;
            end
            tick();
            cyc++;
        end
        scan_ready = 1'b0;
        chk({tag, " beats"}, beat, len);
        if (!rand_rdy) chk({tag, " no gaps"}, cyc, len);
        chk({tag, " done pulse"}, int'(scan_done), 1);
        chk({tag, " valid after"}, int'(scan_valid), 0);
        tick();
        chk({tag, " done end"}, int'(scan_done), 0);
        chk({tag, " busy end"}, int'(busy), 0);
    endtask

    task automatic run_clear(input bit with_scan, input string tag);
        int n;
        bit saw_v;
        clear_req = 1'b1;
        scan_start = with_scan;
        scan_base = 10'd0;
        scan_len = 11'd4;
        tick();
        clear_req = 1'b0;
        scan_start = 1'b0;
        n = 0;
        saw_v = 1'b0;
        while (busy && n < 2000) begin
            if (scan_valid) saw_v = 1'b1;
            we = 1'b0;
            scan_start = 1'b0;
            if (n == 500) begin
                we = 1'b1;
                addr = 10'd3;
                data = 8'h77;
            end
            if (n == 600) scan_start = with_scan;
            tick();
            n++;
        end
        we = 1'b0;
        scan_start = 1'b0;
        chk({tag, " busy cycles"}, n, 1024);
        chk({tag, " no scan"}, int'(saw_v), 0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        repeat (3) tick();
        chk({tag, " idle busy"}, int'(busy), 0);
        chk({tag, " idle valid"}, int'(scan_valid), 0);
    endtask

    initial begin
        int n;
        int beats;
        int a;
        int d;
        bit w;
        logic [7:0] e;

        tbl[0] = '{1'b1, 10'd4, 8'h02, 8'h02};
        tbl[1] = '{1'b0, 10'd4, 8'h00, 8'h02};
        tbl[2] = '{1'b1, 10'd7, 8'h55, 8'h55};
        tbl[3] = '{1'b0, 10'd7, 8'h00, 8'h55};
        tbl[4] = '{1'b1, 10'd4, 8'h99, 8'h99};
        tbl[5] = '{1'b0, 10'd7, 8'h00, 8'h55};
        tbl[6] = '{1'b0, 10'd4, 8'h00, 8'h99};

        rst_n = 1'b0;
        we = 1'b0;
        addr = '0;
        data = '0;
        clear_req = 1'b0;
        scan_start = 1'b0;
        scan_base = '0;
        scan_len = '0;
        scan_ready = 1'b0;
        repeat (3) tick();
        chk("rst out", int'(out), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst valid", int'(scan_valid), 0);
        chk("rst last", int'(scan_last), 0);
        chk("rst done", int'(scan_done), 0);
        chk("rst data", int'(scan_data), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            we = tbl[i].we;
            addr = tbl[i].a;
            data = tbl[i].d;
            tick();
            chk($sformatf("tbl[%0d] out", i), int'(out), int'(tbl[i].exp));
        end
        we = 1'b0;

        cpu_write(0, 8'hAA);
        cpu_write(1023, 8'hBB);
        cpu_read(0, "preload 0");
        cpu_read(1023, "preload 1023");
        run_clear(1'b0, "clear");
        cpu_read(0, "cleared 0");
        cpu_read(1023, "cleared 1023");
        cpu_read(3, "mid-clear write dropped");

        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, 1023));
            d = int'($urandom_range(0, 255));
            we = w;
            addr = a[9:0];
            data = d[7:0];
            e = w ? d[7:0] : ref_mem[a];
            if (w) ref_mem[a] = d[7:0];
            tick();
            chk("rand cpu out", int'(out), int'(e));
        end
        we = 1'b0;

        cpu_write(1022, 1);
        cpu_write(1023, 2);
        cpu_write(0, 3);
        cpu_write(1, 4);
        do_scan(1022, 4, 1'b0, "wrap");
        do_scan(int'($urandom_range(0, 1023)), 8, 1'b1, "backpressure");
        for (int i = 0; i < 5; i++) begin
            do_scan(int'($urandom_range(0, 1023)),
                    int'($urandom_range(1, 40)), 1'b1, "rand scan");
        end
        do_scan(5, 0, 1'b0, "zero");

        run_clear(1'b1, "clear+scan");
        cpu_read(500, "clear+scan mem");

        for (int i = 0; i < 300; i++) begin
            cpu_write(int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
        end
        do_scan(int'($urandom_range(0, 1023)), 1024, 1'b0, "full");

        scan_base = 10'd100;
        scan_len = 11'd16;
        scan_ready = 1'b1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        n = 0;
        beats = 0;
        while (beats < 3 && n < 40) begin
            if (scan_valid) beats++;
            tick();
            n++;
        end
        chk("rst-mid beats", beats, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst-mid valid", int'(scan_valid), 0);
        chk("rst-mid busy", int'(busy), 0);
        scan_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_scan(200, 12, 1'b1, "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_dp.md
Name: vram_dp

Overview:
- Parametrised successor to the single-port 8-bit video RAM.
- CPU-side read/write port keeps the existing one-cycle registered-read behaviour.
- Adds an autonomous scan-out read port that streams a run of words to the video pipeline over a valid/ready handshake.
- Adds a hardware clear engine that fills the array with a constant. Sits between the CPU bus and the pixel/tile fetch logic.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 10, address width; depth is 2**ADDR_W words.
- CLEAR_VALUE, 0, word written to every location by the clear engine (DATA_W bits).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  CPU write enable.
- addr  in  ADDR_W  CPU address.
- data  in  DATA_W  CPU write data.
- out  out  DATA_W  CPU read data, registered.
- clear_req  in  1  pulse: start a full-array clear.
- busy  out  1  high while a clear or a scan is active.
- scan_start  in  1  pulse: start a scan.
- scan_base  in  ADDR_W  first scan address, sampled with scan_start.
- scan_len  in  ADDR_W+1  number of words to stream (0..2**ADDR_W), sampled with scan_start.
- scan_valid  out  1  scan_data valid.
- scan_ready  in  1  consumer accepts the word on an edge where valid && ready.
- scan_data  out  DATA_W  streamed word.
- scan_last  out  1  high with the final word of a scan.
- scan_done  out  1  one-cycle pulse after the final word is accepted, or after a zero-length start.

Behaviour:
- Reset: out, scan_data, scan_valid, scan_last, scan_done and busy all 0; FSM goes to IDLE. Array contents are not reset. Reset asserted mid-clear or mid-scan aborts immediately; the array may be partially cleared.
- CPU port:
  - Every cycle, if we is high and the clear is not active, mem[addr] <= data.
  - out <= mem[addr] on every edge (1-cycle latency).
  - Same-address write and read in the same cycle is write-first: out shows the new data.
  - CPU writes during CLEAR are dropped. CPU reads during CLEAR return the current array contents.
- FSM states: IDLE, CLEAR, SCAN, DONE.
  - IDLE + clear_req -> CLEAR. clear_req wins if scan_start is high in the same cycle.
  - IDLE + scan_start, scan_len=0 -> DONE (no data words).
  - IDLE + scan_start, scan_len>0 -> SCAN. scan_base and scan_len are latched.
  - CLEAR writes CLEAR_VALUE to addresses 0..2**ADDR_W-1, one per cycle, then -> IDLE. busy is high for exactly 2**ADDR_W cycles.
  - SCAN -> DONE on the edge where the last word is accepted.
  - DONE drives scan_done=1 for one cycle, then -> IDLE.
  - clear_req and scan_start are ignored outside IDLE.
  - busy = (state != IDLE).
- Scan port:
  - Read address is scan_base + i modulo 2**ADDR_W, so scans wrap past the top address.
  - A second synchronous read port feeds a 2-entry skid buffer. Throughput is 1 word/cycle while scan_ready is held high.
  - With scan_start sampled at edge N, scan_valid first rises after edge N+2.
  - While valid && !ready, scan_data and scan_last hold stable.
  - Reads are issued only when the buffer has room; no word is ever dropped or duplicated.
  - A CPU write and a scan read of the same address in the same cycle: the scan returns the old data.
  - scan_last is high only on word scan_len-1.
  - scan_valid is 0 outside SCAN.

Test Plan:
- CPU write/read: reset; write mem[4]=2; on the next cycle present addr=4 with we=0 -> out=2 one edge later. Same-cycle write of 0x55 to addr 7 while reading addr 7 -> out=0x55.
- Clear: preload mem[0]=0xAA and mem[1023]=0xBB; pulse clear_req -> busy high for 1024 cycles; afterwards both read 0x00. A CPU write issued mid-clear is not retained.
- Scan with wrap: mem[1022..1023]=1,2 and mem[0..1]=3,4; scan_base=1022, scan_len=4, ready high -> scan_data 1,2,3,4 on consecutive cycles; scan_last on 4; scan_done pulses one cycle later.
- Backpressure: scan_len=8 with scan_ready toggled randomly -> exactly 8 beats accepted, in order, data stable while stalled, no gaps once ready is high.
- Edge cases: scan_len=0 -> scan_done pulses, scan_valid never rises. scan_start and clear_req in the same cycle -> clear runs, scan ignored. scan_start while busy -> ignored. scan_len=1024 -> all 1024 words stream.
- Reset mid-scan: drop rst_n after 3 beats -> scan_valid=0, busy=0 immediately. A new scan after release streams correctly from its new base.
